// File: rtl/load_store_unit_if.sv
// Bus-side handshake between the load/store unit and a single-beat memory port.
interface load_store_unit_if;
   logic        BusValid;
   logic        BusReady;
   logic [31:0] BusAddr;
   logic        BusWe;
   logic [3:0]  BusWStrb;
   logic [31:0] BusWData;
   logic [31:0] BusRData;

   modport master (
      output BusValid, BusAddr, BusWe, BusWStrb, BusWData,
      input  BusReady, BusRData
   );

   modport slave (
      input  BusValid, BusAddr, BusWe, BusWStrb, BusWData,
      output BusReady, BusRData
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns sub-word accesses onto a 32-bit bus, extends load
// results, stalls the pipeline while a bus transaction is in flight, and times out hung buses.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [31:0]               ALUResult,
   input  logic [31:0]               WriteData,
   input  logic [2:0]                Funct3,
   output logic [31:0]               ReadData,
   output logic                      Stall,
   output logic                      AccessFault,
   load_store_unit_if.master         bus
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e      state_q;
   logic        valid_q, we_q, to_fault_q;
   logic [3:0]  strb_q;
   logic [31:0] addr_q, wdata_q, tmo_cnt_q;
   logic [1:0]  lane_q;
   logic [2:0]  f3_q;

   logic        req, legal_f3, misalign, bad;
   logic [3:0]  strb_new;
   logic [31:0] wdata_new, load_val;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      req      = MemRead | MemWrite;
      legal_f3 = MemWrite ? (Funct3 inside {3'b000, 3'b001, 3'b010})
                          : (Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misalign = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                 ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
      bad      = !legal_f3 || misalign;
      case (Funct3[1:0])
         2'b00: begin
            strb_new  = 4'b0001 << ALUResult[1:0];
            wdata_new = {4{WriteData[7:0]}};
         end
         2'b01: begin
            strb_new  = 4'b0011 << ALUResult[1:0];
            wdata_new = {2{WriteData[15:0]}};
         end
         default: begin
            strb_new  = 4'b1111;
            wdata_new = WriteData;
         end
      endcase
   end

   // Lane and size are latched at issue because BusAddr drops the low address bits.
   always_comb begin
      rd_byte = bus.BusRData[{lane_q, 3'b000} +: 8];
      rd_half = lane_q[1] ? bus.BusRData[31:16] : bus.BusRData[15:0];
      unique case (f3_q)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  load_val = {24'h0, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = bus.BusRData;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         valid_q    <= 1'b0;
         we_q       <= 1'b0;
         strb_q     <= 4'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         ReadData   <= 32'h0;
         to_fault_q <= 1'b0;
         tmo_cnt_q  <= 32'h0;
         lane_q     <= 2'b00;
         f3_q       <= 3'b000;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req && !bad) begin
                  state_q   <= StBus;
                  valid_q   <= 1'b1;
                  addr_q    <= {ALUResult[31:2], 2'b00};
                  we_q      <= MemWrite;
                  strb_q    <= MemWrite ? strb_new : 4'h0;
                  wdata_q   <= MemWrite ? wdata_new : 32'h0;
                  lane_q    <= ALUResult[1:0];
                  f3_q      <= Funct3;
                  tmo_cnt_q <= 32'h0;
               end
            end
            StBus: begin
               // A ready on the expiry cycle still completes the access.
               if (bus.BusReady) begin
                  valid_q <= 1'b0;
                  state_q <= StResp;
                  if (!we_q) ReadData <= load_val;
               end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
                  valid_q    <= 1'b0;
                  to_fault_q <= 1'b1;
                  state_q    <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
               end
            end
            StResp: begin
               to_fault_q <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign Stall        = ((state_q == StIdle) && req && !bad) || (state_q == StBus);
   assign AccessFault  = to_fault_q | (rst_n && (state_q == StIdle) && req && bad);
   assign bus.BusValid = valid_q;
   assign bus.BusAddr  = addr_q;
   assign bus.BusWe    = we_q;
   assign bus.BusWStrb = strb_q;
   assign bus.BusWData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural access model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [31:0] ALUResult, WriteData;
   logic [2:0]  Funct3;
   logic [31:0] ReadData;
   logic        Stall, AccessFault;

   int checks   = 0;
   int failures = 0;

   load_store_unit_if bus_if ();

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .ALUResult   (ALUResult),
      .WriteData   (WriteData),
      .Funct3      (Funct3),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .AccessFault (AccessFault),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   // Observations gathered by the access driver.
   int          obs_stall, obs_fault, obs_valid;
   bit          obs_stable, obs_resp_seen;
   logic [31:0] obs_addr, obs_wdata, obs_resp_rd, obs_end_rd;
   logic [3:0]  obs_strb;
   logic        obs_we, obs_resp_stall;

   // Reference model.
   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_fault(input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [2:0] f3);
      bit legal;
      if (!rd && !wr) return 1'b0;
      legal = wr ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      return !legal || ((addr % size_of(f3)) != 0);
   endfunction

   function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [2:0] f3);
      int m;
      m = ((1 << size_of(f3)) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] f3);
      logic [31:0] v;
      v = rdata >> ((addr % 4) * 8);
      if (size_of(f3) == 1) begin
         v = v & 32'hFF;
         if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size_of(f3) == 2) begin
         v = v & 32'hFFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // Issues one request and plays the bus slave; delay<0 means BusReady never rises.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rdata,
                         input int delay);
      int  ncyc;
      bit  hs;
      MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wd; Funct3 = f3;
      obs_stall = 0; obs_fault = 0; obs_valid = 0; obs_stable = 1'b1; obs_resp_seen = 1'b0;
      obs_resp_rd = 32'h0; obs_resp_stall = 1'b0; hs = 1'b0;
      ncyc = (delay < 0) ? 12 : delay + 5;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (hs) begin
            obs_resp_rd = ReadData; obs_resp_stall = Stall; obs_resp_seen = 1'b1; hs = 1'b0;
         end
         obs_stall += int'(Stall);
         obs_fault += int'(AccessFault);
         if (bus_if.BusValid) begin
            obs_valid++;
            if (obs_valid == 1) begin
               obs_addr = bus_if.BusAddr; obs_we = bus_if.BusWe;
               obs_strb = bus_if.BusWStrb; obs_wdata = bus_if.BusWData;
            end else if (obs_addr !== bus_if.BusAddr || obs_we !== bus_if.BusWe ||
                         obs_strb !== bus_if.BusWStrb || obs_wdata !== bus_if.BusWData) begin
               obs_stable = 1'b0;
            end
            if (delay >= 0 && obs_valid == delay + 1) begin
               bus_if.BusReady = 1'b1; bus_if.BusRData = rdata; hs = 1'b1;
            end else begin
               bus_if.BusReady = 1'b0; bus_if.BusRData = $urandom;
            end
         end else begin
            bus_if.BusReady = 1'b0; bus_if.BusRData = $urandom;
         end
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0;
      end
      bus_if.BusReady = 1'b0;
      obs_end_rd = ReadData;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b011;
      ALUResult = 32'h0; WriteData = 32'h0;
      bus_if.BusReady = 1'b1; bus_if.BusRData = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus_if.BusValid, bus_if.BusWe, bus_if.BusWStrb} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: valid/we/strb=%b required 000000",
                  {bus_if.BusValid, bus_if.BusWe, bus_if.BusWStrb});
      end
      checks++;
      if (bus_if.BusAddr !== 32'h0 || bus_if.BusWData !== 32'h0 || ReadData !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h rd=%h required all 0",
                  bus_if.BusAddr, bus_if.BusWData, ReadData);
      end
      checks++;
      if (AccessFault !== 1'b0) begin
         failures++;
         $display("FAIL reset_fault: AccessFault=%b required 0", AccessFault);
      end
      MemRead = 1'b0; bus_if.BusReady = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 0);
      checks++;
      if (!obs_resp_seen || obs_resp_rd !== 32'hDEAD_BEEF || obs_resp_stall !== 1'b0) begin
         failures++;
         $display("FAIL lw_resp: seen=%0d rd=%h stall=%b required 1 deadbeef 0",
                  obs_resp_seen, obs_resp_rd, obs_resp_stall);
      end
      checks++;
      if (obs_stall != 2 || obs_valid != 1 || obs_fault != 0) begin
         failures++;
         $display("FAIL lw_timing: stall=%0d valid=%0d fault=%0d required 2 1 0",
                  obs_stall, obs_valid, obs_fault);
      end
      checks++;
      if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_strb !== 4'h0) begin
         failures++;
         $display("FAIL lw_bus: addr=%h we=%b strb=%b required 100 0 0000",
                  obs_addr, obs_we, obs_strb);
      end
   endtask

   task automatic test_lb_lbu();
      access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 32'h80FF_1234, 0);
      checks++;
      if (obs_resp_rd !== 32'hFFFF_FF80 || obs_addr !== 32'h100) begin
         failures++;
         $display("FAIL lb: rd=%h addr=%h required ffffff80 100", obs_resp_rd, obs_addr);
      end
      access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 32'h80FF_1234, 0);
      checks++;
      if (obs_resp_rd !== 32'h0000_0080) begin
         failures++;
         $display("FAIL lbu: rd=%h required 00000080", obs_resp_rd);
      end
   endtask

   task automatic test_sh();
      access(1'b0, 1'b1, 32'h102, 32'h0000_ABCD, 3'b001, 32'h1111_1111, 0);
      checks++;
      if (obs_addr !== 32'h100 || obs_strb !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD ||
          obs_we !== 1'b1) begin
         failures++;
         $display("FAIL sh_bus: addr=%h strb=%b wdata=%h we=%b required 100 1100 abcdabcd 1",
                  obs_addr, obs_strb, obs_wdata, obs_we);
      end
      checks++;
      if (obs_end_rd !== 32'h0000_0080) begin
         failures++;
         $display("FAIL sh_readdata: rd=%h required 00000080", obs_end_rd);
      end
   endtask

   task automatic test_misaligned();
      access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 32'h5555_5555, 0);
      checks++;
      if (obs_valid != 0 || obs_fault != 1 || obs_stall != 0 || obs_end_rd !== 32'h80) begin
         failures++;
         $display("FAIL misaligned: valid=%0d fault=%0d stall=%0d rd=%h required 0 1 0 80",
                  obs_valid, obs_fault, obs_stall, obs_end_rd);
      end
   endtask

   task automatic test_wait_states();
      access(1'b1, 1'b0, 32'h204, 32'h0, 3'b010, 32'h0BAD_F00D, 3);
      checks++;
      if (obs_valid != 4 || !obs_stable || obs_stall != 5 || obs_fault != 0 ||
          obs_resp_rd !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL wait_load: valid=%0d stable=%0d stall=%0d fault=%0d rd=%h req 4 1 5 0 0badf00d",
                  obs_valid, obs_stable, obs_stall, obs_fault, obs_resp_rd);
      end
      access(1'b0, 1'b1, 32'h305, 32'h1234_56A5, 3'b000, 32'h0, 2);
      checks++;
      if (obs_valid != 3 || !obs_stable || obs_strb !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5) begin
         failures++;
         $display("FAIL wait_store: valid=%0d stable=%0d strb=%b wdata=%h required 3 1 0010 a5a5a5a5",
                  obs_valid, obs_stable, obs_strb, obs_wdata);
      end
   endtask

   task automatic test_timeout();
      access(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 32'h0, -1);
      checks++;
      if (obs_valid != 4 || obs_fault != 1 || obs_stall != 5 || obs_end_rd !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL timeout: valid=%0d fault=%0d stall=%0d rd=%h required 4 1 5 0badf00d",
                  obs_valid, obs_fault, obs_stall, obs_end_rd);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_rd;
      exp_rd = ReadData;
      for (int n = 0; n < 60; n++) begin
         logic        rd, wr, flt;
         logic [31:0] addr, wd, rdata;
         logic [2:0]  f3;
         int          dly;
         rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; wd = $urandom;
         rdata = $urandom; f3 = 3'($urandom); dly = int'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
         flt = model_fault(rd, wr, addr, f3);
         access(rd, wr, addr, wd, f3, rdata, dly);
         if (!flt && (rd || wr) && !wr) exp_rd = model_load(rdata, addr, f3);
         checks++;
         if (!(rd || wr) || flt) begin
            if (obs_valid != 0 || obs_stall != 0 || obs_fault != int'(flt)) begin
               failures++;
               $display("FAIL rand_nobus[%0d]: valid=%0d stall=%0d fault=%0d required 0 0 %0d",
                        n, obs_valid, obs_stall, obs_fault, flt);
            end
         end else if (obs_valid != dly + 1 || obs_stall != dly + 2 || obs_fault != 0 ||
                      !obs_stable || obs_addr !== {addr[31:2], 2'b00} || obs_we !== wr ||
                      obs_strb !== (wr ? model_strb(addr, f3) : 4'h0) ||
                      (wr && obs_wdata !== model_wdata(wd, f3))) begin
            failures++;
            $display("FAIL rand_bus[%0d]: valid=%0d stall=%0d addr=%h we=%b strb=%b wdata=%h req %0d %0d %h %b %b %h",
                     n, obs_valid, obs_stall, obs_addr, obs_we, obs_strb, obs_wdata, dly + 1,
                     dly + 2, {addr[31:2], 2'b00}, wr, wr ? model_strb(addr, f3) : 4'h0,
                     model_wdata(wd, f3));
         end
         checks++;
         if (obs_end_rd !== exp_rd) begin
            failures++;
            $display("FAIL rand_rd[%0d]: rd=%h required %h", n, obs_end_rd, exp_rd);
         end
      end
   endtask

   task automatic test_reset_mid_bus();
      bit bad_after;
      access(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 32'hCAFE_0001, 0);
      MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h600; Funct3 = 3'b010;
      @(negedge clk);
      @(posedge clk); #1;
      MemRead = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.BusValid !== 1'b0 || ReadData !== 32'h0 || AccessFault !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_bus: valid=%b rd=%h fault=%b required 0 0 0",
                  bus_if.BusValid, ReadData, AccessFault);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad_after = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus_if.BusReady = 1'b1;
         if (bus_if.BusValid || AccessFault || Stall || ReadData !== 32'h0) bad_after = 1'b1;
         @(posedge clk); #1;
      end
      bus_if.BusReady = 1'b0;
      checks++;
      if (bad_after) begin
         failures++;
         $display("FAIL reset_release: activity after release required idle with ReadData 0");
      end
   endtask

   initial begin
      bus_if.BusReady = 1'b0;
      bus_if.BusRData = 32'h0;
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_misaligned();
      test_wait_states();
      test_timeout();
      test_random();
      test_reset_mid_bus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles in BUS before abort; 0 disables the timeout.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-004 SHALL have port MemRead  in  1  MEM-stage load request.
REQ-005 SHALL have port MemWrite  in  1  MEM-stage store request; MemWrite wins when both MemRead and MemWrite are high.
REQ-006 SHALL have port ALUResult  in  32  byte address.
REQ-007 SHALL have port WriteData  in  32  store data; the value sits in the low bits.
REQ-008 SHALL have port Funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port ReadData  out  32  extended load result, which feeds the writeback select.
REQ-010 SHALL have port Stall  out  1  combinational hold request to the pipeline.
REQ-011 SHALL have port AccessFault  out  1  one-cycle pulse on a misaligned access, an illegal Funct3, or a timeout.
REQ-012 SHALL have port BusValid  out  1  bus request valid.
REQ-013 SHALL have port BusReady  in  1  bus request accepted and completed.
REQ-014 SHALL have port BusAddr  out  32  word-aligned address.
REQ-015 SHALL have port BusWe  out  1  write enable.
REQ-016 SHALL have port BusWStrb  out  4  byte lane strobes.
REQ-017 SHALL have port BusWData  out  32  lane-replicated store data.
REQ-018 SHALL have port BusRData  in  32  read data, valid when BusValid and BusReady are both high.

Function
REQ-019 SHALL implement states IDLE, BUS and RESP; the reset state is IDLE.
REQ-020 In IDLE with a request that is aligned and has a legal Funct3, SHALL register the bus outputs and go to BUS; BusValid rises on the next cycle.
REQ-021 SHALL treat H with ALUResult[0]=1, W with ALUResult[1:0]!=0, or Funct3 of 011, 110 or 111 (011 also for stores), as a fault.
REQ-022 On a fault, SHALL issue no bus request, pulse AccessFault in that same cycle, hold Stall low, and leave ReadData unchanged.
REQ-023 Stores SHALL accept only Funct3 000, 001 and 010; any other store Funct3 is a fault.
REQ-024 SHALL drive BusAddr = {ALUResult[31:2], 2'b00}.
REQ-025 SHALL drive BusWStrb for stores as: SB = 0001<<ALUResult[1:0]; SH = 0011<<ALUResult[1:0]; SW = 1111.
REQ-026 SHALL drive BusWStrb = 0000 and BusWe = 0 for loads.
REQ-027 SHALL drive BusWData as: SB = byte replicated x4; SH = half replicated x2; SW = WriteData.
REQ-028 SHALL hold BusAddr, BusWe, BusWStrb and BusWData stable while BusValid=1 and BusReady=0; BusValid SHALL NOT drop before the handshake except on timeout or reset.
REQ-029 When BusValid and BusReady are both high in BUS, SHALL capture the load result into ReadData and go to RESP; BusValid drops on the next cycle.
REQ-030 SHALL extract the load result by lane ALUResult[1:0]: B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-031 SHALL leave ReadData unchanged on stores; ReadData holds the last completed load.
REQ-032 SHALL drive Stall = (IDLE and valid request) or BUS; Stall is low in RESP, which lasts one cycle and then returns to IDLE.
REQ-033 Minimum memory-instruction occupancy SHALL be 3 cycles: IDLE, BUS with BusReady high, RESP.
REQ-034 With TIMEOUT_CYCLES nonzero, after TIMEOUT_CYCLES consecutive cycles in BUS without BusReady, SHALL drop BusValid, pulse AccessFault, leave ReadData unchanged, and go to RESP.
REQ-035 A BusReady in the same cycle as the timeout expiry SHALL count as completion, not as a fault.
REQ-036 A new request arriving in RESP SHALL be ignored; it is evaluated in the following IDLE.

Reset
REQ-037 rst_n low SHALL immediately force IDLE, BusValid=0, BusWe=0, BusWStrb=0, BusAddr=0, BusWData=0, ReadData=0, AccessFault=0 and clear the timeout counter.
REQ-038 Stall SHALL then follow REQ-032.
REQ-039 Reset asserted during BUS SHALL abandon the transaction; no RESP and no fault follow.

Verification
REQ-040 LW at 0x100, BusReady high in the first BusValid cycle, BusRData=0xDEADBEEF -> ReadData=0xDEADBEEF in RESP; Stall high exactly 2 cycles.
REQ-041 LB at 0x103, BusRData=0x80FF1234 -> ReadData=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-042 SH at 0x102, WriteData=0x0000ABCD -> BusAddr=0x100, BusWStrb=1100, BusWData=0xABCDABCD, BusWe=1; ReadData unchanged.
REQ-043 LW at 0x101 -> BusValid never rises; AccessFault high 1 cycle; Stall low.
REQ-044 BusReady withheld 3 cycles -> bus outputs bit-stable, Stall high; completion on the 4th cycle; then TIMEOUT_CYCLES=4 with BusReady never high -> BusValid drops after 4 cycles and AccessFault pulses.
REQ-045 rst_n pulsed low mid-BUS -> BusValid=0 asynchronously; after release, state IDLE and ReadData=0.
